// File: rtl/dport_capture_fifo.sv
// Capture FIFO for the system data port: buffers core output bytes, drains them
// over a valid/ready stream, tracks run/flush/finish from done and counts drops.
module dport_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             done_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             late_write,
  output logic [7:0]       drop_count,
  output logic             finished
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_FINISHED = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             full;
  logic             pop;
  logic             push;
  logic             drop_full;
  logic             drop_late;
  logic [AW:0]      count_next;

  // Push/pop qualification and next occupancy; only registered state feeds outputs.
  always_comb begin
    full       = (count == (AW+1)'(DEPTH));
    pop        = out_valid & out_ready;
    push       = (state == S_RUN) & wr_en & (~full | pop);
    drop_full  = (state == S_RUN) & wr_en & full & ~pop;
    drop_late  = (state != S_RUN) & wr_en;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; contents need no reset since out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // First-word fall-through head; forced to zero whenever the FIFO is empty.
  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // Pointers, occupancy, drop tracking and run/flush/finish state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      late_write <= 1'b0;
      drop_count <= 8'd0;
      finished   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_next;
      out_valid <= (count_next != '0);

      if (drop_full) begin
        overflow <= 1'b1;
      end
      if (drop_late) begin
        late_write <= 1'b1;
      end
      if ((drop_full | drop_late) && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end

      case (state)
        S_RUN: begin
          if (done_in) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (count == '0) begin
            state    <= S_FINISHED;
            finished <= 1'b1;
          end
        end
        S_FINISHED: begin
          state <= S_FINISHED;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dport_capture_fifo.sv
// Directed bench for dport_capture_fifo: streaming, overflow, push+pop at full,
// pointer wrap, late writes after done, empty flush, and asynchronous reset.
module tb_dport_capture_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       done_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       overflow;
  logic       late_write;
  logic [7:0] drop_count;
  logic       finished;

  int errors = 0;
  int checks = 0;

  dport_capture_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .done_in    (done_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .overflow   (overflow),
    .late_write (late_write),
    .drop_count (drop_count),
    .finished   (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    done_in   = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    done_in   = 1'b0;
    out_ready = 1'b0;
    #2;

    // Reset state
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_flags", 32'({overflow, late_write, finished}), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    // 1: streaming with latency 1
    out_ready = 1'b1;
    wr_en = 1'b1; wr_data = 8'h11; tick();
    check("t1_data0", 32'(out_data), 32'h11);
    check("t1_valid0", 32'(out_valid), 32'd1);
    wr_data = 8'h22; tick();
    check("t1_data1", 32'(out_data), 32'h22);
    check("t1_count1", 32'(count), 32'd1);
    wr_data = 8'h33; tick();
    check("t1_data2", 32'(out_data), 32'h33);
    wr_en = 1'b0; tick();
    check("t1_empty_valid", 32'(out_valid), 32'd0);
    check("t1_empty_count", 32'(count), 32'd0);
    tick();
    check("t1_no_underflow", 32'(count), 32'd0);

    // 2: overflow with out_ready low, then ordered drain
    do_reset();
    out_ready = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    check("t2_count", 32'(count), 32'd16);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_drop", 32'(drop_count), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", 32'(out_data), 32'(i));
      tick();
    end
    check("t2_drained", 32'(count), 32'd0);

    // 3: push+pop on full, then 40-byte wrapping stream
    do_reset();
    out_ready = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(8'h80 + i);
      tick();
    end
    check("t3_full", 32'(count), 32'd16);
    wr_data = 8'hAA; out_ready = 1'b1; tick();
    wr_en = 1'b0;
    check("t3_count_same", 32'(count), 32'd16);
    check("t3_no_overflow", 32'(overflow), 32'd0);
    check("t3_no_drop", 32'(drop_count), 32'd0);
    for (int i = 1; i < 16; i++) begin
      check("t3_drain", 32'(out_data), 32'(8'h80 + i));
      tick();
    end
    check("t3_last", 32'(out_data), 32'hAA);
    tick();
    check("t3_empty", 32'(count), 32'd0);
    wr_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = 8'(8'h40 + i);
      tick();
      check("t3_stream", 32'(out_data), 32'(8'h40 + i));
    end
    wr_en = 1'b0; tick();
    check("t3_stream_empty", 32'(count), 32'd0);
    check("t3_stream_drop", 32'(drop_count), 32'd0);

    // 4: late write after done, finish after drain
    do_reset();
    out_ready = 1'b0;
    wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0; done_in = 1'b1; tick();
    check("t4_count", 32'(count), 32'd3);
    wr_en = 1'b1; wr_data = 8'h55; tick();
    wr_en = 1'b0;
    check("t4_late", 32'(late_write), 32'd1);
    check("t4_drop", 32'(drop_count), 32'd1);
    check("t4_count_kept", 32'(count), 32'd3);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check("t4_drain", 32'(out_data), 32'(i));
      tick();
    end
    check("t4_empty", 32'(out_valid), 32'd0);
    check("t4_not_fin_yet", 32'(finished), 32'd0);
    done_in = 1'b0; tick();
    check("t4_finished", 32'(finished), 32'd1);
    tick();
    check("t4_fin_sticky", 32'(finished), 32'd1);
    check("t4_no_55", 32'({out_valid, out_data}), 32'd0);

    // 5: done with empty FIFO
    do_reset();
    done_in = 1'b1; tick();
    check("t5_flush", 32'(finished), 32'd0);
    tick();
    check("t5_finished", 32'(finished), 32'd1);
    done_in = 1'b0;

    // 6: asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'hC0 + i);
      tick();
    end
    wr_en = 1'b0;
    check("t6_count5", 32'(count), 32'd5);
    #1 rst = 1'b0;
    #1;
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_data", 32'(out_data), 32'h00);
    tick();
    rst = 1'b1;
    tick();
    check("t6_post_count", 32'(count), 32'd0);
    check("t6_post_fin", 32'(finished), 32'd0);
    wr_en = 1'b1; wr_data = 8'h7E; tick();
    wr_en = 1'b0;
    check("t6_run_write", 32'(out_data), 32'h7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
